// File: rtl/pc_fetch_if.sv
// Fetch-stage bus: hazard/branch inputs, instruction-memory port and IF/ID outputs.
// The master drives control and memory data; the fetch unit is the slave.
interface pc_fetch_if #(
  parameter int CNT_W = 16
);
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic [31:0]      imem_rdata;
  logic [31:0]      imem_addr;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] fetch_count;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, redirect_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump, jump_target, imem_rdata,
    output imem_addr, if_id_instr, if_id_pc4, if_id_valid, fetch_count, redirect_count
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and saturating
// fetch/redirect event counters. Priority per cycle is reset, redirect, stall, advance.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic         clk,
  input  logic         rst,
  pc_fetch_if.slave    bus
);

  logic [31:0]      pc_q,          pc_d;
  logic [31:0]      instr_q,       instr_d;
  logic [31:0]      pc4_q,         pc4_d;
  logic             valid_q,       valid_d;
  logic [CNT_W-1:0] fetch_cnt_q,   fetch_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q,   redir_cnt_d;

  logic             redirect_s;
  logic [31:0]      target_s;
  logic [31:0]      pc_plus4_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] res;
    if (value == {CNT_W{1'b1}}) begin
      res = value;
    end else begin
      res = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  assign pc_plus4_s = pc_q + 32'd4;

  // Redirect decode: branch beats jump; targets are forced word-aligned.
  always_comb begin
    redirect_s = bus.branch_taken | bus.jump;
    if (bus.branch_taken) begin
      target_s = {bus.branch_target[31:2], 2'b00};
    end else begin
      target_s = {bus.jump_target[31:2], 2'b00};
    end
  end

  // Next-state selection; a redirect discards a stalled wrong-path IF/ID entry.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (redirect_s) begin
      pc_d        = target_s;
      instr_d     = 32'h0000_0000;
      pc4_d       = 32'h0000_0000;
      valid_d     = 1'b0;
      redir_cnt_d = sat_inc(redir_cnt_q);
    end else if (!bus.stall) begin
      pc_d        = pc_plus4_s;
      instr_d     = bus.imem_rdata;
      pc4_d       = pc_plus4_s;
      valid_d     = 1'b1;
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end else begin
      pc_d        = pc_q;
      instr_d     = instr_q;
      pc4_d       = pc4_q;
      valid_d     = valid_q;
      fetch_cnt_d = fetch_cnt_q;
      redir_cnt_d = redir_cnt_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'h0000_0000;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      fetch_cnt_q <= {CNT_W{1'b0}};
      redir_cnt_q <= {CNT_W{1'b0}};
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.if_id_instr    = instr_q;
  assign bus.if_id_pc4      = pc4_q;
  assign bus.if_id_valid    = valid_q;
  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.redirect_count = redir_cnt_q;

endmodule
